imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered immediate-decode stage for the decode pipeline. It accepts one 32-bit instruction per cycle over a valid/ready handshake and produces the sign- or zero-extended immediate at XLEN width. It adds CSR-zimm and shift-amount immediate types, and can optionally derive the immediate type from the opcode. A 2-entry skid buffer keeps `in_ready` free of any combinational path from `out_ready`. It sits between fetch/instruction buffer and register read.

## Interface
- `XLEN`, default 32: output immediate width; legal values 32 and 64.
- `AUTO_SEL`, default 0: 0 means the type comes from `in_imm_sel`; 1 means it is decoded from the opcode and `in_imm_sel` is ignored.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  stage can accept a word.
- `in_instr`  in  32  instruction word.
- `in_imm_sel`  in  3  immediate type, used when `AUTO_SEL`=0.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  downstream accepts.
- `out_imm`  out  XLEN  extended immediate.
- `out_instr`  out  32  instruction passed through unchanged.
- `out_illegal`  out  1  opcode not recognised (`AUTO_SEL`=1 only, else 0).

## Operation
Immediate types (`sel`). `s` means sign-extend from `in[31]` to XLEN.
- 000 I: s, in[31:20].
- 001 U: s, {in[31:12], 12'b0}. Sign-extended above bit 31 when XLEN=64.
- 010 J: s, {in[31], in[19:12], in[20], in[30:21], 0}.
- 011 B: s, {in[31], in[7], in[30:25], in[11:8], 0}.
- 100 S: s, {in[31:25], in[11:7]}.
- 101 Z: zero-extended in[19:15].
- 110 SH: zero-extended in[25:20] when XLEN=64, in[24:20] when XLEN=32.
- 111: all zeros.

`AUTO_SEL`=1 opcode map (in[6:0]); any opcode not listed gives sel 111 and `out_illegal`=1.
- 0010011 (OP-IMM): SH if funct3 is 001 or 101, else I.
- 0000011, 1100111, 0001111: I.
- 0110111, 0010111: U.
- 1101111: J.
- 1100011: B.
- 0100011: S.
- 1110011: Z if in[14]=1, else I.
- 0110011, 0111011: 111, `out_illegal`=0.
- 0011011 (OP-IMM-32): only when XLEN=64. SH if funct3 is 001 or 101, with the shamt field forced to 5 bits (in[24:20]); else I. Illegal when XLEN=32.

Buffer: a main output register plus one skid register. State is held as `cnt` in {0, 1, 2}.
- `in_ready` = (cnt != 2). It depends on registered state only.
- `out_valid` = (cnt != 0). The outputs always show the main register.
- Push = `in_valid` & `in_ready`. Pop = `out_valid` & `out_ready`.
- cnt 0: push → main, go to 1.
- cnt 1, push only: word → skid, go to 2.
- cnt 1, pop only: go to 0.
- cnt 1, push and pop: word → main, stay at 1.
- cnt 2, pop: skid → main, go to 1. No push is possible in this state.
- Decode is done before the register, so stored values are final.
- Flush (priority below `rst`, above everything else): cnt ← 0. A push in the same cycle is dropped. Register contents are don't-care, but `out_valid` must be 0 on the next cycle.

## Timing
- Latency: a word pushed at edge N is visible with `out_valid`=1 from edge N to edge N+1.
- Throughput is 1 word/cycle while `out_ready`=1.
- Reset values: cnt=0, `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_instr`=0, `out_illegal`=0. Main and skid data registers are also cleared.
- Reset mid-transfer discards both entries; no output is produced for them.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` may fall only as a result of a push while cnt=1 with no pop.
- Each word is emitted exactly once and in order.

## Test plan
- XLEN=32, `AUTO_SEL`=0: push 0xFFF00093 with sel 000, `out_ready`=1 → next cycle `out_valid`=1, `out_imm`=0xFFFFFFFF. Push 0x8000006F with sel 010 → `out_imm`=0xFFF00000.
- XLEN=64, `AUTO_SEL`=1: push 0x800002B7 (LUI) → `out_imm`=0xFFFFFFFF80000000. Push 0x03F59593 (SLLI, shamt 63) → `out_imm`=63. Push 0x0002D073 (CSRWI, zimm 5) → `out_imm`=5. Push 0x0000007F → `out_illegal`=1, `out_imm`=0.
- Backpressure: `out_ready`=0 and push A, B → `in_ready`=0 after B, C is held. Raise `out_ready` → A, B, C emerge on consecutive cycles, with no loss and no duplication.
- Simultaneous push/pop at cnt=1 for 8 cycles → 8 outputs in order, `in_ready` stays 1.
- Flush while cnt=2 with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed words never appear.
- Assert `rst` with cnt=2 → next cycle all outputs at reset values. After release, a push emerges one cycle later.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Registered immediate decode with a 2-entry skid buffer.
// in_ready depends only on the registered occupancy count.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit AUTO_SEL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_imm_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [31:0]     out_instr,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [31:0]     instr;
        logic            illegal;
    } entry_t;

    localparam logic [2:0] SEL_I  = 3'b000;
    localparam logic [2:0] SEL_U  = 3'b001;
    localparam logic [2:0] SEL_J  = 3'b010;
    localparam logic [2:0] SEL_B  = 3'b011;
    localparam logic [2:0] SEL_S  = 3'b100;
    localparam logic [2:0] SEL_Z  = 3'b101;
    localparam logic [2:0] SEL_SH = 3'b110;
    localparam logic [2:0] SEL_0  = 3'b111;

    logic [2:0] sel;
    logic       illegal;
    logic       sh5;
    logic       sh_f3;
    logic       sign;
    logic       sh_hi;
    entry_t     d;
    entry_t     main_q;
    entry_t     skid_q;
    logic [1:0] cnt;
    logic       push;
    logic       pop;

    assign sh_f3 = (in_instr[13:12] == 2'b01);
    assign sign  = in_instr[31];

    always_comb begin
        sel     = in_imm_sel;
        illegal = 1'b0;
        sh5     = 1'b0;
        if (AUTO_SEL) begin
            sel = SEL_0;
            unique case (in_instr[6:0])
                7'b0010011: sel = sh_f3 ? SEL_SH : SEL_I;
                7'b0000011,
                7'b1100111,
                7'b0001111: sel = SEL_I;
                7'b0110111,
                7'b0010111: sel = SEL_U;
                7'b1101111: sel = SEL_J;
                7'b1100011: sel = SEL_B;
                7'b0100011: sel = SEL_S;
                7'b1110011: sel = in_instr[14] ? SEL_Z : SEL_I;
                7'b0110011,
                7'b0111011: sel = SEL_0;
                7'b0011011: begin
                    if (XLEN == 64) begin
                        sel = sh_f3 ? SEL_SH : SEL_I;
                        sh5 = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Word shifts on RV64 keep a 5-bit shamt
    assign sh_hi = (XLEN == 64) && !sh5 && in_instr[25];

    always_comb begin
        d.instr   = in_instr;
        d.illegal = illegal;
        d.imm     = '0;
        case (sel)
            SEL_I:  d.imm = {{(XLEN-11){sign}}, in_instr[30:20]};
            SEL_U:  d.imm = {{(XLEN-31){sign}}, in_instr[30:12], 12'b0};
            SEL_J:  d.imm = {{(XLEN-20){sign}}, in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            SEL_B:  d.imm = {{(XLEN-12){sign}}, in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            SEL_S:  d.imm = {{(XLEN-11){sign}}, in_instr[30:25],
                             in_instr[11:7]};
            SEL_Z:  d.imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            SEL_SH: d.imm = {{(XLEN-6){1'b0}}, sh_hi, in_instr[24:20]};
            default: d.imm = '0;
        endcase
    end

    assign in_ready    = (cnt != 2'd2);
    assign out_valid   = (cnt != 2'd0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign out_imm     = main_q.imm;
    assign out_instr   = main_q.instr;
    assign out_illegal = main_q.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 2'd0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        main_q <= d;
                        cnt    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        main_q <= d;
                    end else if (push) begin
                        skid_q <= d;
                        cnt    <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        main_q <= skid_q;
                        cnt    <= 2'd1;
                    end
                end
                default: cnt <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: XLEN=32 manual select and XLEN=64 opcode decode.
module tb_imm_decode_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid;
    logic        a_out_ready, a_out_illegal;
    logic [31:0] a_in_instr, a_out_instr, a_out_imm;
    logic [2:0]  a_in_imm_sel;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid;
    logic        b_out_ready, b_out_illegal;
    logic [31:0] b_in_instr, b_out_instr;
    logic [63:0] b_out_imm;
    logic [2:0]  b_in_imm_sel;

    int n_chk = 0;
    int n_fail = 0;

    imm_decode_stage #(.XLEN(32), .AUTO_SEL(1'b0)) u32 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_imm_sel(a_in_imm_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_imm(a_out_imm), .out_instr(a_out_instr),
        .out_illegal(a_out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .AUTO_SEL(1'b1)) u64 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_imm_sel(b_in_imm_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_instr(b_out_instr),
        .out_illegal(b_out_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] w, input logic [2:0] s);
        a_in_valid   = 1'b1;
        a_in_instr   = w;
        a_in_imm_sel = s;
    endtask

    task automatic a_word(input string tag, input logic [31:0] w,
                          input logic [2:0] s, input logic [63:0] imm);
        push_a(w, s);
        tick();
        chk({tag, "_v"}, {63'b0, a_out_valid}, 64'd1);
        chk({tag, "_imm"}, {32'b0, a_out_imm}, imm);
    endtask

    task automatic b_word(input string tag, input logic [31:0] w,
                          input logic [63:0] imm, input logic ill);
        b_in_valid = 1'b1;
        b_in_instr = w;
        tick();
        chk({tag, "_v"}, {63'b0, b_out_valid}, 64'd1);
        chk({tag, "_imm"}, b_out_imm, imm);
        chk({tag, "_ill"}, {63'b0, b_out_illegal}, {63'b0, ill});
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_in_instr = '0; a_in_imm_sel = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_in_instr = '0; b_in_imm_sel = 3'b101;
        tick();
        tick();
        chk("rst_a_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rst_a_ready", {63'b0, a_in_ready}, 64'd1);
        chk("rst_a_imm", {32'b0, a_out_imm}, 64'd0);
        chk("rst_b_valid", {63'b0, b_out_valid}, 64'd0);
        chk("rst_b_imm", b_out_imm, 64'd0);
        chk("rst_b_ill", {63'b0, b_out_illegal}, 64'd0);
        rst = 1'b0;

        // XLEN=32, explicit select
        a_word("a_i_neg", 32'hFFF00093, 3'b000, 64'h0000_0000_FFFF_FFFF);
        chk("a_i_neg_instr", {32'b0, a_out_instr}, 64'hFFF00093);
        a_word("a_j", 32'h8000006F, 3'b010, 64'h0000_0000_FFF0_0000);
        a_word("a_i_pos", 32'h00500093, 3'b000, 64'd5);
        a_word("a_u", 32'h12345037, 3'b001, 64'h1234_5000);
        a_word("a_b", 32'h80000063, 3'b011, 64'h0000_0000_FFFF_F000);
        a_word("a_s", 32'h00A12623, 3'b100, 64'd12);
        a_word("a_z", 32'h0002D073, 3'b101, 64'd5);
        a_word("a_sh", 32'h03F59593, 3'b110, 64'd31);
        a_word("a_zero", 32'hFFFFFFFF, 3'b111, 64'd0);
        a_in_valid = 1'b0;
        tick();
        chk("a_drain", {63'b0, a_out_valid}, 64'd0);

        // XLEN=64, opcode decode
        b_word("b_lui", 32'h800002B7, 64'hFFFF_FFFF_8000_0000, 1'b0);
        b_word("b_slli", 32'h03F59593, 64'd63, 1'b0);
        b_word("b_srai", 32'h4030D093, 64'd3, 1'b0);
        b_word("b_csrwi", 32'h0002D073, 64'd5, 1'b0);
        b_word("b_csrrw", 32'h30051073, 64'd768, 1'b0);
        b_word("b_slliw", 32'h03F5959B, 64'd31, 1'b0);
        b_word("b_addi", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        b_word("b_beq", 32'h80000063, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
        b_word("b_add", 32'h00B50533, 64'd0, 1'b0);
        b_word("b_bad", 32'h0000007F, 64'd0, 1'b1);
        chk("b_bad_instr", {32'b0, b_out_instr}, 64'h0000007F);
        b_in_valid = 1'b0;
        tick();
        chk("b_drain", {63'b0, b_out_valid}, 64'd0);

        // Backpressure: A, B fill the buffer, C waits
        a_out_ready = 1'b0;
        push_a(32'h00100093, 3'b000);
        tick();
        chk("bp_a_ready1", {63'b0, a_in_ready}, 64'd1);
        push_a(32'h00200093, 3'b000);
        tick();
        chk("bp_full", {63'b0, a_in_ready}, 64'd0);
        chk("bp_show_a", {32'b0, a_out_instr}, 64'h00100093);
        push_a(32'h00300093, 3'b000);
        tick();
        chk("bp_hold_rdy", {63'b0, a_in_ready}, 64'd0);
        chk("bp_hold_a", {32'b0, a_out_imm}, 64'd1);
        a_out_ready = 1'b1;
        tick();
        chk("bp_b_instr", {32'b0, a_out_instr}, 64'h00200093);
        chk("bp_b_imm", {32'b0, a_out_imm}, 64'd2);
        tick();
        chk("bp_c_instr", {32'b0, a_out_instr}, 64'h00300093);
        chk("bp_c_valid", {63'b0, a_out_valid}, 64'd1);
        a_in_valid = 1'b0;
        tick();
        chk("bp_empty", {63'b0, a_out_valid}, 64'd0);

        // Streaming: push and pop together
        for (int k = 0; k < 8; k++) begin
            push_a(32'h00000093 | (32'(k + 16) << 20), 3'b000);
            tick();
            chk("st_imm", {32'b0, a_out_imm}, 64'(k + 16));
            chk("st_ready", {63'b0, a_in_ready}, 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("st_empty", {63'b0, a_out_valid}, 64'd0);

        // Flush at cnt=2 with a push pending
        a_out_ready = 1'b0;
        push_a(32'h07B00093, 3'b000);
        tick();
        push_a(32'h07C00093, 3'b000);
        tick();
        chk("fl_full", {63'b0, a_in_ready}, 64'd0);
        a_flush = 1'b1;
        push_a(32'h07D00093, 3'b000);
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        chk("fl_valid", {63'b0, a_out_valid}, 64'd0);
        chk("fl_ready", {63'b0, a_in_ready}, 64'd1);
        a_out_ready = 1'b1;
        tick();
        chk("fl_gone", {63'b0, a_out_valid}, 64'd0);

        // Reset with both entries occupied
        a_out_ready = 1'b0;
        push_a(32'hFFF00093, 3'b000);
        tick();
        push_a(32'h80000063, 3'b000);
        tick();
        a_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rr_ready", {63'b0, a_in_ready}, 64'd1);
        chk("rr_imm", {32'b0, a_out_imm}, 64'd0);
        chk("rr_instr", {32'b0, a_out_instr}, 64'd0);
        a_out_ready = 1'b1;
        push_a(32'h02A00093, 3'b000);
        tick();
        a_in_valid = 1'b0;
        chk("rr_after_v", {63'b0, a_out_valid}, 64'd1);
        chk("rr_after_imm", {32'b0, a_out_imm}, 64'd42);
        tick();
        chk("rr_end", {63'b0, a_out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
